// File: rtl/vote_xchg_pkg.sv
// vote_xchg_pkg: shared state encoding, self-test pattern and parity helper
// for the vote exchange controller.
package vote_xchg_pkg;

    typedef enum logic [3:0] {
        STARTUP  = 4'd0,
        STANDBY  = 4'd1,
        GET_IN   = 4'd2,
        START_TX = 4'd3,
        SEND     = 4'd4,
        TX_2_RX  = 4'd5,
        RECEIVE  = 4'd6,
        RX_2_TX  = 4'd7,
        END_TX   = 4'd8,
        TEST_1   = 4'd9,
        TEST_2   = 4'd10,
        ABORT    = 4'd11
    } state_t;

    // Alternating self-test vote, bit0 set; sliced to VOTE_W by the user.
    localparam logic [7:0] ALT_PATTERN = 8'h55;

    // XOR reduction over a zero-padded frame. Returns the bit that makes the
    // whole thing even when used as a parity bit, and 1 on a bad even-parity frame.
    function automatic logic even_par(input logic [8:0] bits_i);
        return ^bits_i;
    endfunction

endpackage

// File: rtl/vote_btn_edge.sv
// vote_btn_edge: per-bit rising-edge detector for the vote buttons. Edges are
// only reported while key is high; last_btn is updated only in the entry
// window with key high, and can be cleared at session start.
module vote_btn_edge #(
    parameter int VOTE_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              sample,
    input  logic              key,
    input  logic [VOTE_W-1:0] btn,
    output logic [VOTE_W-1:0] rise
);

    logic [VOTE_W-1:0] last_btn_r;

    // Remember the button levels seen during vote entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_btn_r <= {VOTE_W{1'b0}};
        end else if (clr) begin
            last_btn_r <= {VOTE_W{1'b0}};
        end else if (sample && key) begin
            last_btn_r <= btn;
        end else begin
            last_btn_r <= last_btn_r;
        end
    end

    // Report buttons that went from released to pressed while enabled.
    always_comb begin
        rise = {VOTE_W{1'b0}};
        if (key) begin
            rise = btn & ~last_btn_r;
        end else begin
            rise = {VOTE_W{1'b0}};
        end
    end

endmodule

// File: rtl/vote_xchg.sv
// vote_xchg: two-party vote exchange controller. Collects a vote from toggle
// buttons, sends it as {parity, vote} over a cts/ctr - rts/rtr handshake and
// repeats until both sides agree or the round limit aborts the session.
// Optional self-test path (TEST_1/TEST_2) is compiled in with VOTE_TEST_EN.
module vote_xchg
    import vote_xchg_pkg::*;
#(
    parameter int VOTE_W     = 3,
    parameter int MAX_ROUNDS = 4,
    parameter int RND_W      = $clog2(MAX_ROUNDS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              test,
    input  logic              start,
    input  logic              key,
    input  logic [VOTE_W-1:0] btn,
    input  logic              rts,
    input  logic              rtr,
    input  logic [VOTE_W:0]   v_in,
    output logic              cts,
    output logic              ctr,
    output logic [VOTE_W:0]   v_out,
    output logic              agree,
    output logic              abort,
    output logic              perr,
    output logic [RND_W-1:0]  round
);

    localparam logic [RND_W-1:0] ROUND_LIM = RND_W'(MAX_ROUNDS);

    state_t             state_r, state_nx;
    logic [VOTE_W-1:0]  vote_r, vote_nx;
    logic               par_r, par_nx;
    logic [RND_W-1:0]   round_r, round_nx;
    logic               cts_r, cts_nx;
    logic               ctr_r, ctr_nx;
    logic [VOTE_W:0]    v_out_r, v_out_nx;
    logic               agree_r, agree_nx;
    logic               abort_r, abort_nx;
    logic               perr_r, perr_nx;
    logic [RND_W-1:0]   round_inc_s;
    logic               matched_s;
    logic               btn_clr_s;
    logic               btn_sample_s;
    logic [VOTE_W-1:0]  rise_s;

`ifndef VOTE_TEST_EN
    // Mode select only matters when the self-test path is built.
    logic test_unused_s;
    assign test_unused_s = test;
`endif

    vote_btn_edge #(.VOTE_W(VOTE_W)) u_btn_edge (
        .clock  (clock),
        .reset  (reset),
        .clr    (btn_clr_s),
        .sample (btn_sample_s),
        .key    (key),
        .btn    (btn),
        .rise   (rise_s)
    );

    // Next-state and next-output logic for the session FSM.
    always_comb begin
        state_nx     = state_r;
        vote_nx      = vote_r;
        par_nx       = par_r;
        round_nx     = round_r;
        cts_nx       = cts_r;
        ctr_nx       = ctr_r;
        v_out_nx     = v_out_r;
        agree_nx     = agree_r;
        abort_nx     = abort_r;
        perr_nx      = perr_r;
        matched_s    = 1'b0;
        btn_clr_s    = 1'b0;
        btn_sample_s = 1'b0;
        // Round count saturates so it never wraps past the limit.
        if (round_r == ROUND_LIM) begin
            round_inc_s = round_r;
        end else begin
            round_inc_s = round_r + RND_W'(1'b1);
        end

        case (state_r)
            STARTUP: begin
                vote_nx = {VOTE_W{1'b0}};
                cts_nx  = 1'b0;
                ctr_nx  = 1'b0;
`ifdef VOTE_TEST_EN
                if (!test) begin
                    state_nx = TEST_1;
                end else begin
                    state_nx = STANDBY;
                end
`else
                state_nx = STANDBY;
`endif
            end
            STANDBY: begin
                cts_nx = rtr;
                if (start) begin
                    vote_nx   = {VOTE_W{1'b0}};
                    round_nx  = {RND_W{1'b0}};
                    agree_nx  = 1'b0;
                    abort_nx  = 1'b0;
                    perr_nx   = 1'b0;
                    btn_clr_s = 1'b1;
                    state_nx  = GET_IN;
                end else begin
                    state_nx = STANDBY;
                end
            end
            GET_IN: begin
                // Closing the entry window wins over any button activity.
                if (!start) begin
                    state_nx = START_TX;
                end else if (key) begin
                    btn_sample_s = 1'b1;
                    vote_nx      = vote_r ^ rise_s;
                end else begin
                    vote_nx = {VOTE_W{1'b0}};
                end
            end
            START_TX: begin
                par_nx   = even_par(9'(vote_r));
                state_nx = SEND;
            end
            SEND: begin
                if (rtr) begin
                    v_out_nx = {par_r, vote_r};
                    cts_nx   = 1'b1;
                    state_nx = TX_2_RX;
                end else begin
                    state_nx = SEND;
                end
            end
            TX_2_RX: begin
                if (!rts) begin
                    ctr_nx   = 1'b1;
                    state_nx = RECEIVE;
                end else begin
                    state_nx = TX_2_RX;
                end
            end
            RECEIVE: begin
                if (rts) begin
                    ctr_nx   = 1'b0;
                    round_nx = round_inc_s;
                    if (even_par(9'(v_in))) begin
                        // Corrupt frame: keep our vote and retransmit it.
                        perr_nx = 1'b1;
                    end else if (v_in[VOTE_W-1:0] == vote_r) begin
                        matched_s = 1'b1;
                    end else begin
                        vote_nx = v_in[VOTE_W-1:0];
                        par_nx  = v_in[VOTE_W];
                    end
                    // Agreement beats the round limit in the same round.
                    if (matched_s) begin
                        state_nx = END_TX;
                    end else if (round_inc_s == ROUND_LIM) begin
                        state_nx = ABORT;
                    end else begin
                        state_nx = RX_2_TX;
                    end
                end else begin
                    state_nx = RECEIVE;
                end
            end
            RX_2_TX: begin
                if (!rtr) begin
                    cts_nx   = 1'b0;
                    state_nx = SEND;
                end else begin
                    state_nx = RX_2_TX;
                end
            end
            END_TX: begin
                if (!rtr) begin
                    cts_nx   = 1'b0;
                    agree_nx = 1'b1;
                    state_nx = STANDBY;
                end else begin
                    state_nx = END_TX;
                end
            end
            ABORT: begin
                abort_nx = 1'b1;
                cts_nx   = 1'b0;
                ctr_nx   = 1'b0;
                state_nx = STANDBY;
            end
`ifdef VOTE_TEST_EN
            TEST_1: begin
                vote_nx = v_in[VOTE_W-1:0];
                if (&v_in[VOTE_W-1:0]) begin
                    state_nx = TEST_2;
                end else begin
                    state_nx = TEST_1;
                end
            end
            TEST_2: begin
                vote_nx  = ALT_PATTERN[VOTE_W-1:0];
                par_nx   = even_par(9'(ALT_PATTERN[VOTE_W-1:0]));
                state_nx = SEND;
            end
`endif
            default: begin
                state_nx = STARTUP;
            end
        endcase
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= STARTUP;
            vote_r  <= {VOTE_W{1'b0}};
            par_r   <= 1'b0;
            round_r <= {RND_W{1'b0}};
            cts_r   <= 1'b0;
            ctr_r   <= 1'b0;
            v_out_r <= {(VOTE_W+1){1'b0}};
            agree_r <= 1'b0;
            abort_r <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            vote_r  <= vote_nx;
            par_r   <= par_nx;
            round_r <= round_nx;
            cts_r   <= cts_nx;
            ctr_r   <= ctr_nx;
            v_out_r <= v_out_nx;
            agree_r <= agree_nx;
            abort_r <= abort_nx;
            perr_r  <= perr_nx;
        end
    end

    assign cts   = cts_r;
    assign ctr   = ctr_r;
    assign v_out = v_out_r;
    assign agree = agree_r;
    assign abort = abort_r;
    assign perr  = perr_r;
    assign round = round_r;

endmodule
